ultrasonic_ranger: RTL and testbench
====================================

Name: ultrasonic_ranger

Overview:
- Sensor-side front end for the obstacle-detection path. Drives one HC-SR04-style ultrasonic transducer: emits the trigger pulse, then times the echo pulse.
- Converts echo width to centimetres without a divider and raises the per-sensor obstacle level that the downstream OR/flip-flop/buzzer logic consumes.
- The stick uses one instance per sensor (three total).

Parameters:
TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz)
TICKS_PER_CM, 2900, clk cycles of echo-high per centimetre of range (58 us/cm at 50 MHz)
MAX_ECHO_CYCLES, 1200000, wait-for-rise limit and measure limit; either expiring is a timeout
PERIOD_CYCLES, 3000000, cycles between successive trigger rising edges
THRESH_CM, 100, obstacle threshold in cm
DIST_W, 9, width of distance_cm

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
echo_in  in  1  raw asynchronous echo line from transducer
trig_out  out  1  trigger pulse to transducer
distance_cm  out  DIST_W  last measured range in cm, saturating
dist_valid  out  1  one-cycle pulse when distance_cm updates
timeout  out  1  one-cycle pulse when a measurement finds no echo
obstacle  out  1  level: 1 when last valid distance_cm <= THRESH_CM

Behaviour:
- Reset state: rst is sampled on posedge clk. All outputs, counters and synchronizer flops go to 0, and the FSM goes to TRIG_ST.
- Reset mid-operation: rst asserted in any state aborts the measurement. No dist_valid or timeout is produced for the aborted cycle.
- First trigger: trig_out rises on the first clock edge after the edge where rst is sampled low.
- echo_in synchronization: 2-flop synchronizer feeding an edge detector (prev/cur). Raw transitions are seen 2 cycles late.
- FSM TRIG_ST: trig_out=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
- FSM WAIT_RISE: trig_out=0. On synced rising edge, go to MEASURE with the high-cycle count H=1. If MAX_ECHO_CYCLES cycles elapse first, pulse timeout and go to IDLE. An echo already high at TRIG_ST exit is not a rise; the FSM waits for low-then-high.
- FSM MEASURE: per cycle with synced echo high, H++. A cm counter increments each time the sub-counter reaches TICKS_PER_CM (sub-counter then resets). This yields distance = floor(H/TICKS_PER_CM) with no divider. The cm counter saturates at 2^DIST_W-1.
  - On synced falling edge: register distance_cm, pulse dist_valid, update obstacle, go to IDLE.
  - If H reaches MAX_ECHO_CYCLES first: pulse timeout, leave distance_cm unchanged, go to IDLE.
- FSM IDLE: wait until the period counter expires, then go to TRIG_ST.
- Period counter: counts from each trigger rising edge. Trigger rising edges are exactly PERIOD_CYCLES apart regardless of the measurement outcome.
- Latency: raw echo falling edge at cycle n gives dist_valid high at cycle n+3, with distance_cm valid in that same cycle.
- obstacle updates: set to (distance <= THRESH_CM) together with dist_valid; forced to 0 on timeout (no echo = clear path); otherwise held.
- Distance 0: an echo shorter than TICKS_PER_CM reports 0 and sets obstacle=1.
- dist_valid and timeout are never high in the same cycle.
- Elaboration assertion: PERIOD_CYCLES > TRIG_CYCLES + 2*MAX_ECHO_CYCLES + 4.

Decomposition:
- Shared package (ranger_pkg): the FSM state enum {TRIG_ST, WAIT_RISE, MEASURE, IDLE}, default timing constants for 50 MHz, and the period-constraint check function.
- Sub-module echo_sync: 2-flop synchronizer plus registered edge detect. Outputs are level, rise and fall. It is reused by any other asynchronous sensor input.

Test Plan:
Bench parameters for all scenarios: TRIG_CYCLES=4, TICKS_PER_CM=10, MAX_ECHO_CYCLES=200, PERIOD_CYCLES=500, THRESH_CM=5, DIST_W=4.
1. Trigger timing: rst held 3 cycles, then released -> trig_out high exactly 4 cycles starting the first edge after release. Next trig rise occurs exactly 500 cycles later. All outputs are 0 during rst.
2. Far object: echo_in high 73 cycles, starting 10 cycles after trig falls -> distance_cm=7, dist_valid one cycle, 3 cycles after the raw fall; obstacle=0.
3. Near object: echo_in high 45 cycles -> distance_cm=4, dist_valid pulse, obstacle=1. A following cycle with echo 73 -> obstacle returns to 0.
4. No echo: echo_in held low -> timeout pulse 200 cycles after trig falls; distance_cm retains previous value; obstacle=0; no dist_valid.
5. Saturation, timeout and stuck line:
   - echo high 180 cycles -> distance_cm=15 (saturated), dist_valid.
   - echo high 250 cycles -> timeout at H=200, no dist_valid.
   - echo stuck high from before the trigger -> timeout.
6. Reset mid-measure: assert rst 1 cycle after echo rise -> no dist_valid/timeout; all outputs 0; trig_out restarts 1 cycle after rst is released.

Source files
------------

// File: rtl/ranger_pkg.sv
// rtl/ranger_pkg.sv - shared FSM encoding, default 50 MHz timing and period sanity check
package ranger_pkg;

    // Default timing for a 50 MHz system clock
    localparam int DEF_TRIG_CYCLES     = 500;      // 10 us trigger pulse
    localparam int DEF_TICKS_PER_CM    = 2900;     // 58 us of echo per centimetre
    localparam int DEF_MAX_ECHO_CYCLES = 1200000;  // 24 ms wait / measure limit
    localparam int DEF_PERIOD_CYCLES   = 3000000;  // 60 ms between triggers
    localparam int DEF_THRESH_CM       = 100;
    localparam int DEF_DIST_W          = 9;

    // Measurement FSM encoding
    typedef logic [1:0] ranger_state_t;
    localparam ranger_state_t TRIG_ST   = 2'd0;
    localparam ranger_state_t WAIT_RISE = 2'd1;
    localparam ranger_state_t MEASURE   = 2'd2;
    localparam ranger_state_t IDLE      = 2'd3;

    // A full trigger + worst-case wait + worst-case measure must fit inside one period,
    // otherwise the period counter would wrap while a measurement is still running.
    function automatic bit period_ok(input int trig_cycles,
                                     input int max_echo_cycles,
                                     input int period_cycles);
        return period_cycles > (trig_cycles + 2 * max_echo_cycles + 4);
    endfunction

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - two-flop synchronizer with level, rise and fall outputs
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two metastability flops, then a copy of the synchronized level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Edges are decoded from registered values only, so they are glitch free and
    // appear in the same cycle the synchronized level first changes.
    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;
    assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - HC-SR04 trigger generator and divider-free echo-to-cm ranger
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int TRIG_CYCLES     = DEF_TRIG_CYCLES,
    parameter int TICKS_PER_CM    = DEF_TICKS_PER_CM,
    parameter int MAX_ECHO_CYCLES = DEF_MAX_ECHO_CYCLES,
    parameter int PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
    parameter int THRESH_CM       = DEF_THRESH_CM,
    parameter int DIST_W          = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              echo_in,
    output logic              trig_out,
    output logic [DIST_W-1:0] distance_cm,
    output logic              dist_valid,
    output logic              timeout,
    output logic              obstacle
);

    localparam int PER_W = $clog2(PERIOD_CYCLES);
    localparam int CNT_W = $clog2(MAX_ECHO_CYCLES + 1);
    localparam int SUB_W = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

    // Period counter values: 0 is the post-wrap slot, 1..TRIG_CYCLES drive the trigger
    localparam logic [PER_W-1:0]  PER_ZERO      = '0;
    localparam logic [PER_W-1:0]  PER_TRIG_EXIT = PER_W'(TRIG_CYCLES + 1);
    localparam logic [PER_W-1:0]  PER_LAST      = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(MAX_ECHO_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
    localparam logic [SUB_W-1:0]  SUB_LAST      = SUB_W'(TICKS_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX        = '1;
    localparam logic [31:0]       THRESH_U      = 32'(THRESH_CM);

    if (!period_ok(TRIG_CYCLES, MAX_ECHO_CYCLES, PERIOD_CYCLES)) begin : g_bad_period
        $error("ultrasonic_ranger: PERIOD_CYCLES too short for trigger plus two echo limits");
    end

    logic echo_level;
    logic echo_rise;
    logic echo_fall;

    echo_sync u_echo_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (echo_in),
        .level_o (echo_level),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    ranger_state_t     state_q, state_d;
    logic [PER_W-1:0]  per_q,   per_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [SUB_W-1:0]  sub_q,   sub_d;
    logic [DIST_W-1:0] cm_q,    cm_d;
    logic [DIST_W-1:0] dist_q,  dist_d;
    logic              trig_q,  trig_d;
    logic              valid_q, valid_d;
    logic              tmo_q,   tmo_d;
    logic              obst_q,  obst_d;

    logic [SUB_W-1:0]  sub_base;
    logic [DIST_W-1:0] cm_base;
    logic [SUB_W-1:0]  tick_sub;
    logic [DIST_W-1:0] tick_cm;

    // One echo-high cycle worth of progress on the sub-counter / cm counter pair.
    // Outside MEASURE the pair starts from zero, so the first high cycle counts too.
    always_comb begin
        sub_base = (state_q == MEASURE) ? sub_q : '0;
        cm_base  = (state_q == MEASURE) ? cm_q  : '0;
        if (sub_base == SUB_LAST) begin
            tick_sub = '0;
            tick_cm  = (cm_base == CM_MAX) ? cm_base : cm_base + 1'b1;
        end else begin
            tick_sub = sub_base + 1'b1;
            tick_cm  = cm_base;
        end
    end

    // Measurement sequencing: trigger, wait for echo rise, time the echo, idle out the period
    always_comb begin
        state_d = state_q;
        per_d   = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        dist_d  = dist_q;
        trig_d  = trig_q;
        valid_d = 1'b0;
        tmo_d   = 1'b0;
        obst_d  = obst_q;

        case (state_q)
            TRIG_ST: begin
                if (per_q == PER_TRIG_EXIT) begin
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end else if (per_q != PER_ZERO) begin
                    trig_d = 1'b1;
                end
            end

            WAIT_RISE: begin
                // A line already high when the trigger ends shows no rise and times out.
                if (echo_rise) begin
                    cnt_d   = CNT_ONE;
                    sub_d   = tick_sub;
                    cm_d    = tick_cm;
                    state_d = MEASURE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    obst_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            MEASURE: begin
                if (echo_fall) begin
                    dist_d  = cm_q;
                    valid_d = 1'b1;
                    obst_d  = (32'(cm_q) <= THRESH_U);
                    state_d = IDLE;
                end else if (echo_level) begin
                    // Counting this cycle would make the high count reach the limit.
                    if (cnt_q == CNT_LAST) begin
                        tmo_d   = 1'b1;
                        obst_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        sub_d = tick_sub;
                        cm_d  = tick_cm;
                    end
                end
            end

            IDLE: begin
                // Leaving on the wrap keeps trigger rises exactly one period apart.
                if (per_q == PER_LAST) begin
                    state_d = TRIG_ST;
                end
            end

            default: begin
                trig_d  = 1'b0;
                state_d = TRIG_ST;
            end
        endcase
    end

    // State registers; reset aborts any measurement without reporting it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TRIG_ST;
            per_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            dist_q  <= '0;
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            obst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            dist_q  <= dist_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            obst_q  <= obst_d;
        end
    end

    assign trig_out    = trig_q;
    assign distance_cm = dist_q;
    assign dist_valid  = valid_q;
    assign timeout     = tmo_q;
    assign obstacle    = obst_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - table-driven and randomized check of ultrasonic_ranger
module tb_ultrasonic_ranger;

    localparam int TRIG  = 4;
    localparam int TICKS = 10;
    localparam int MAXE  = 200;
    localparam int PER   = 500;
    localparam int THR   = 5;
    localparam int DW    = 4;
    localparam int DMAX  = (1 << DW) - 1;

    typedef struct {
        int         delay;
        int         len;
        bit         stuck;
        bit         exp_valid;
        logic [3:0] exp_dist;
        bit         exp_obst;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          echo_in = 1'b0;
    logic          trig_out;
    logic [DW-1:0] distance_cm;
    logic          dist_valid;
    logic          timeout;
    logic          obstacle;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int model_dist = 0;
    bit model_obst = 1'b0;
    int seen_valid = 0;
    int seen_tmo = 0;

    ultrasonic_ranger #(
        .TRIG_CYCLES     (TRIG),
        .TICKS_PER_CM    (TICKS),
        .MAX_ECHO_CYCLES (MAXE),
        .PERIOD_CYCLES   (PER),
        .THRESH_CM       (THR),
        .DIST_W          (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .echo_in     (echo_in),
        .trig_out    (trig_out),
        .distance_cm (distance_cm),
        .dist_valid  (dist_valid),
        .timeout     (timeout),
        .obstacle    (obstacle)
    );

    always #5 clk = ~clk;

    wire [7:0] obs = {trig_out, dist_valid, timeout, distance_cm, obstacle};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Runs ncyc cycles of one trigger period starting at the trigger rise cycle.
    // Echo rises delay cycles after the trigger falls and stays high len cycles.
    task automatic run_period(input int delay, input int len, input bit stuck, input int ncyc);
        int p, t, evt, dist_e;
        bit evt_valid;
        logic [7:0] expv;
        p = rise_cyc + TRIG;
        t = p + delay;
        evt_valid = 1'b0;
        dist_e = 0;
        if (stuck || len == 0 || delay + 2 > MAXE - 1) begin
            evt = p + MAXE;
        end else if (len >= MAXE) begin
            evt = t + 2 + MAXE;
        end else begin
            evt = t + len + 3;
            evt_valid = 1'b1;
            dist_e = len / TICKS;
            if (dist_e > DMAX) dist_e = DMAX;
        end
        seen_valid = 0;
        seen_tmo = 0;
        for (int rel = 0; rel < ncyc; rel++) begin
            echo_in = stuck || (len > 0 && cyc >= t && cyc < t + len);
            if (cyc == evt) begin
                if (evt_valid) begin
                    model_dist = dist_e;
                    model_obst = (dist_e <= THR);
                end else begin
                    model_obst = 1'b0;
                end
            end
            expv = {rel < TRIG, (cyc == evt) && evt_valid, (cyc == evt) && !evt_valid,
                    4'(model_dist), model_obst};
            check("cycle", 32'(obs), 32'(expv));
            seen_valid += int'(dist_valid);
            seen_tmo += int'(timeout);
            tick();
        end
    endtask

    initial begin
        vec_t tbl [16];
        tbl[0]  = '{10,  73,  1'b0, 1'b1, 4'd7,  1'b0};
        tbl[1]  = '{10,  45,  1'b0, 1'b1, 4'd4,  1'b1};
        tbl[2]  = '{10,  73,  1'b0, 1'b1, 4'd7,  1'b0};
        tbl[3]  = '{10,  45,  1'b0, 1'b1, 4'd4,  1'b1};
        tbl[4]  = '{0,   0,   1'b0, 1'b0, 4'd4,  1'b0};
        tbl[5]  = '{10,  180, 1'b0, 1'b1, 4'd15, 1'b0};
        tbl[6]  = '{10,  250, 1'b0, 1'b0, 4'd15, 1'b0};
        tbl[7]  = '{3,   5,   1'b0, 1'b1, 4'd0,  1'b1};
        tbl[8]  = '{0,   0,   1'b1, 1'b0, 4'd0,  1'b0};
        tbl[9]  = '{20,  59,  1'b0, 1'b1, 4'd5,  1'b1};
        tbl[10] = '{20,  60,  1'b0, 1'b1, 4'd6,  1'b0};
        tbl[11] = '{20,  199, 1'b0, 1'b1, 4'd15, 1'b0};
        tbl[12] = '{20,  200, 1'b0, 1'b0, 4'd15, 1'b0};
        tbl[13] = '{197, 5,   1'b0, 1'b1, 4'd0,  1'b1};
        tbl[14] = '{198, 5,   1'b0, 1'b0, 4'd0,  1'b0};
        tbl[15] = '{10,  10,  1'b0, 1'b1, 4'd1,  1'b1};

        rst = 1'b1;
        echo_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outputs", 32'(obs), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("first_edge_after_release", 32'(obs), 32'd0);
        tick();
        rise_cyc = cyc;

        foreach (tbl[i]) begin
            run_period(tbl[i].delay, tbl[i].len, tbl[i].stuck, PER);
            rise_cyc += PER;
            check("vec_valid_count", 32'(seen_valid), 32'(int'(tbl[i].exp_valid)));
            check("vec_timeout_count", 32'(seen_tmo), 32'(int'(!tbl[i].exp_valid)));
            check("vec_distance", 32'(distance_cm), 32'(tbl[i].exp_dist));
            check("vec_obstacle", 32'(obstacle), 32'(tbl[i].exp_obst));
        end

        for (int i = 0; i < 20; i++) begin
            bit st;
            st = ($urandom_range(0, 9) == 0);
            run_period(int'($urandom_range(0, 150)), int'($urandom_range(0, 260)), st, PER);
            rise_cyc += PER;
        end

        // Reset one cycle after the FSM has entered MEASURE
        run_period(10, 1000, 1'b0, TRIG + 10 + 4);
        echo_in = 1'b0;
        rst = 1'b1;
        check("abort_before_reset", 32'(obs), 32'({3'b000, 4'(model_dist), model_obst}));
        tick();
        check("abort_in_reset", 32'(obs), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_release_edge", 32'(obs), 32'd0);
        tick();
        rise_cyc = cyc;
        model_dist = 0;
        model_obst = 1'b0;
        run_period(0, 0, 1'b0, PER);
        check("abort_then_timeout", 32'(seen_tmo), 32'd1);
        check("abort_then_no_valid", 32'(seen_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
